// File: rtl/phys_regfile_fwd.sv
// Physical register file with ready scoreboard, CDB bypass, zero-init sweep
// and sticky write-conflict detection.
module phys_regfile_fwd #(
  parameter int PHYS_REGS = 64,
  parameter int XLEN      = 32,
  parameter int N_READ    = 2,
  parameter int N_WRITE   = 2,
  parameter int N_ALLOC   = 1,
  localparam int PHYS_BITS = $clog2(PHYS_REGS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_ALLOC-1:0]                alloc_valid,
  input  logic [N_ALLOC-1:0][PHYS_BITS-1:0] alloc_pd,
  input  logic [N_WRITE-1:0]                wr_valid,
  input  logic [N_WRITE-1:0][PHYS_BITS-1:0] wr_pd,
  input  logic [N_WRITE-1:0][XLEN-1:0]      wr_data,
  input  logic [N_READ-1:0][PHYS_BITS-1:0]  rd_ps1,
  input  logic [N_READ-1:0][PHYS_BITS-1:0]  rd_ps2,
  output logic [N_READ-1:0][XLEN-1:0]       rd_ps1_v,
  output logic [N_READ-1:0][XLEN-1:0]       rd_ps2_v,
  output logic [N_READ-1:0]                 rd_ps1_rdy,
  output logic [N_READ-1:0]                 rd_ps2_rdy,
  input  logic                              flush,
  output logic                              init_busy,
  output logic                              wr_conflict
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int NS = 2 * N_READ;

  logic [0:0]           state_q, state_d;
  logic [PHYS_BITS-1:0] idx_q, idx_d;
  logic [PHYS_REGS-1:0] rdy_q, rdy_d;
  logic                 conf_q, conf_d;
  logic [XLEN-1:0]      mem_q [PHYS_REGS];
  logic                 run;
  logic                 hit;

  logic [NS-1:0][PHYS_BITS-1:0] ps;
  logic [NS-1:0][XLEN-1:0]      rv;
  logic [NS-1:0]                rr;

  assign run         = (state_q == S_RUN);
  assign init_busy   = !run;
  assign wr_conflict = conf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!run) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == PHYS_BITS'(PHYS_REGS - 1)) state_d = S_RUN;
    end
  end

  // Later assignments override earlier ones: flush beats alloc beats write.
  always_comb begin
    rdy_d = rdy_q;
    if (run) begin
      for (int j = 0; j < N_WRITE; j++)
        if (wr_valid[j] && wr_pd[j] != '0) rdy_d[wr_pd[j]] = 1'b1;
      for (int a = 0; a < N_ALLOC; a++)
        if (alloc_valid[a] && alloc_pd[a] != '0) rdy_d[alloc_pd[a]] = 1'b0;
      if (flush) rdy_d = '1;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < N_WRITE; j++) begin
      for (int k = j + 1; k < N_WRITE; k++)
        if (wr_valid[j] && wr_valid[k] && wr_pd[j] == wr_pd[k] &&
            wr_pd[j] != '0) hit = 1'b1;
      for (int a = 0; a < N_ALLOC; a++)
        if (wr_valid[j] && alloc_valid[a] && wr_pd[j] == alloc_pd[a] &&
            wr_pd[j] != '0) hit = 1'b1;
    end
    conf_d = conf_q | (run & hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      rdy_q   <= '1;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      conf_q  <= conf_d;
    end
  end

  // Data array has no reset; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int j = 0; j < N_WRITE; j++)
        if (wr_valid[j] && wr_pd[j] != '0) mem_q[wr_pd[j]] <= wr_data[j];
    end
  end

  always_comb begin
    rd_ps1_v   = '0;
    rd_ps2_v   = '0;
    rd_ps1_rdy = '0;
    rd_ps2_rdy = '0;
    rv         = '0;
    rr         = '0;
    for (int i = 0; i < N_READ; i++) begin
      ps[i]          = rd_ps1[i];
      ps[N_READ + i] = rd_ps2[i];
    end
    for (int k = 0; k < NS; k++) begin
      if (run) begin
        if (ps[k] == '0) begin
          rr[k] = 1'b1;
        end else begin
          rv[k] = mem_q[ps[k]];
          rr[k] = rdy_q[ps[k]];
          for (int j = 0; j < N_WRITE; j++)
            if (wr_valid[j] && wr_pd[j] == ps[k]) begin
              rv[k] = wr_data[j];
              rr[k] = 1'b1;
            end
        end
      end
    end
    for (int i = 0; i < N_READ; i++) begin
      rd_ps1_v[i]   = rv[i];
      rd_ps1_rdy[i] = rr[i];
      rd_ps2_v[i]   = rv[N_READ + i];
      rd_ps2_rdy[i] = rr[N_READ + i];
    end
  end

endmodule

// File: tb/tb_phys_regfile_fwd.sv
// Bench for phys_regfile_fwd: directed table, corner sequences and a
// randomized run against an array-based reference model.
module tb_phys_regfile_fwd;

  logic clk;
  logic rst_n;
  logic [0:0]      alloc_valid;
  logic [0:0][5:0] alloc_pd;
  logic [1:0]      wr_valid;
  logic [1:0][5:0] wr_pd;
  logic [1:0][31:0] wr_data;
  logic [1:0][5:0] rd_ps1, rd_ps2;
  logic [1:0][31:0] rd_ps1_v, rd_ps2_v;
  logic [1:0]      rd_ps1_rdy, rd_ps2_rdy;
  logic            flush;
  logic            init_busy;
  logic            wr_conflict;

  phys_regfile_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_pd(alloc_pd),
    .wr_valid(wr_valid), .wr_pd(wr_pd), .wr_data(wr_data),
    .rd_ps1(rd_ps1), .rd_ps2(rd_ps2),
    .rd_ps1_v(rd_ps1_v), .rd_ps2_v(rd_ps2_v),
    .rd_ps1_rdy(rd_ps1_rdy), .rd_ps2_rdy(rd_ps2_rdy),
    .flush(flush), .init_busy(init_busy), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mdata [64];
  logic        mrdy  [64];
  logic        mconf;
  int          init_left;

  typedef struct {
    logic        av;
    logic [5:0]  apd;
    logic [1:0]  wv;
    logic [5:0]  p0, p1;
    logic [31:0] d0, d1;
    logic        fl;
    logic [5:0]  ps;
    logic [31:0] ev;
    logic        er;
    logic        ec;
  } vec_t;

  vec_t tv [15];

  function automatic vec_t mk(int av, int apd, int wv, int p0, int d0,
                              int p1, int d1, int fl, int ps, int ev,
                              int er, int ec);
    vec_t v;
    v.av = 1'(av); v.apd = 6'(apd); v.wv = 2'(wv);
    v.p0 = 6'(p0); v.d0 = 32'(d0); v.p1 = 6'(p1); v.d1 = 32'(d1);
    v.fl = 1'(fl); v.ps = 6'(ps); v.ev = 32'(ev);
    v.er = 1'(er); v.ec = 1'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    alloc_valid = '0; alloc_pd = '0;
    wr_valid = '0; wr_pd = '0; wr_data = '0;
    flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mdata[i] = '0;
      mrdy[i]  = 1'b1;
    end
    mconf = 1'b0;
    init_left = 64;
  endtask

  task automatic mread(input logic [5:0] p, output logic [31:0] v,
                       output logic r);
    v = '0; r = 1'b0;
    if (init_left == 0) begin
      if (p == 0) begin
        r = 1'b1;
      end else begin
        v = mdata[p]; r = mrdy[p];
        for (int j = 0; j < 2; j++)
          if (wr_valid[j] && wr_pd[j] == p) begin
            v = wr_data[j]; r = 1'b1;
          end
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (init_left > 0) begin
      init_left--;
      return;
    end
    if (wr_valid == 2'b11 && wr_pd[0] == wr_pd[1] && wr_pd[0] != 0)
      mconf = 1'b1;
    for (int j = 0; j < 2; j++)
      if (wr_valid[j] && alloc_valid[0] && wr_pd[j] == alloc_pd[0] &&
          wr_pd[j] != 0) mconf = 1'b1;
    for (int j = 0; j < 2; j++)
      if (wr_valid[j] && wr_pd[j] != 0) begin
        mdata[wr_pd[j]] = wr_data[j];
        mrdy[wr_pd[j]]  = 1'b1;
      end
    if (flush) begin
      for (int i = 0; i < 64; i++) mrdy[i] = 1'b1;
    end else if (alloc_valid[0] && alloc_pd[0] != 0) begin
      mrdy[alloc_pd[0]] = 1'b0;
    end
  endtask

  // Compare every output against the model, then clock one edge.
  task automatic step();
    logic [31:0] v;
    logic r;
    #1;
    chk("busy", 32'(init_busy), 32'(init_left > 0));
    chk("conflict", 32'(wr_conflict), 32'(mconf));
    for (int c = 0; c < 2; c++) begin
      mread(rd_ps1[c], v, r);
      chk("ps1_v", rd_ps1_v[c], v);
      chk("ps1_rdy", 32'(rd_ps1_rdy[c]), 32'(r));
      mread(rd_ps2[c], v, r);
      chk("ps2_v", rd_ps2_v[c], v);
      chk("ps2_rdy", 32'(rd_ps2_rdy[c]), 32'(r));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic rand_reads();
    for (int c = 0; c < 2; c++) begin
      rd_ps1[c] = 6'($urandom_range(0, 63));
      rd_ps2[c] = 6'($urandom_range(0, 63));
    end
  endtask

  initial begin
    tv[0]  = mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 32'hDEADBEEF, 1, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 32'hDEADBEEF, 1, 0);
    tv[4]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    tv[5]  = mk(1, 4, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    tv[6]  = mk(0, 0, 1, 3, 5, 0, 0, 0, 4, 0, 0, 0);
    tv[7]  = mk(1, 4, 0, 0, 0, 0, 0, 1, 3, 5, 1, 0);
    tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 32'hDEADBEEF, 1, 0);
    tv[10] = mk(0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 1, 0);
    tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[13] = mk(0, 0, 3, 9, 32'h11, 9, 32'h22, 0, 9, 32'h22, 1, 0);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h22, 1, 1);

    rst_n = 1'b0;
    idle_in();
    rd_ps1 = '0; rd_ps2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sweep after reset: 64 busy cycles with zeroed reads.
    for (int c = 0; c < 64; c++) begin
      rand_reads();
      #1;
      chk("init_busy_hi", 32'(init_busy), 32'd1);
      chk("init_rd_v", rd_ps1_v[0], 32'd0);
      chk("init_rd_rdy", 32'(rd_ps1_rdy[0]), 32'd0);
      step();
    end
    rd_ps1[0] = 6'd5;
    #1;
    chk("init_busy_lo", 32'(init_busy), 32'd0);
    chk("p5_v", rd_ps1_v[0], 32'd0);
    chk("p5_rdy", 32'(rd_ps1_rdy[0]), 32'd1);
    step();

    for (int i = 0; i < 15; i++) begin
      alloc_valid[0] = tv[i].av; alloc_pd[0] = tv[i].apd;
      wr_valid = tv[i].wv;
      wr_pd[0] = tv[i].p0; wr_data[0] = tv[i].d0;
      wr_pd[1] = tv[i].p1; wr_data[1] = tv[i].d1;
      flush = tv[i].fl;
      rd_ps1[0] = tv[i].ps; rd_ps2[0] = tv[i].ps;
      rd_ps1[1] = 6'($urandom_range(0, 63));
      rd_ps2[1] = 6'($urandom_range(0, 63));
      #1;
      chk($sformatf("tv%0d_v", i), rd_ps1_v[0], tv[i].ev);
      chk($sformatf("tv%0d_rdy", i), 32'(rd_ps2_rdy[0]), 32'(tv[i].er));
      chk($sformatf("tv%0d_conf", i), 32'(wr_conflict), 32'(tv[i].ec));
      step();
    end
    idle_in();

    // Flush left every preg ready.
    for (int p = 0; p < 64; p++) begin
      rd_ps1[0] = 6'(p);
      #1;
      chk($sformatf("all_rdy_p%0d", p), 32'(rd_ps1_rdy[0]), 32'd1);
      step();
    end
    repeat (10) step();
    chk("conf_sticky", 32'(wr_conflict), 32'd1);

    for (int c = 0; c < 400; c++) begin
      alloc_valid[0] = 1'($urandom_range(0, 1));
      alloc_pd[0] = 6'($urandom_range(0, 7));
      wr_valid = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wr_pd[j] = 6'($urandom_range(0, 7));
        wr_data[j] = $urandom;
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 2; k++) begin
        rd_ps1[k] = 6'($urandom_range(0, 7));
        rd_ps2[k] = 6'($urandom_range(0, 7));
      end
      step();
    end
    idle_in();

    // Re-reset mid-run, then again mid-sweep at idx 30.
    pulse_reset();
    #1;
    chk("rst_conf_clr", 32'(wr_conflict), 32'd0);
    repeat (30) step();
    pulse_reset();
    for (int c = 0; c < 64; c++) begin
      wr_valid = 2'b01; wr_pd[0] = 6'd2; wr_data[0] = 32'h9;
      rd_ps1[0] = 6'd2;
      #1;
      chk("resweep_busy", 32'(init_busy), 32'd1);
      step();
    end
    idle_in();
    rd_ps1[0] = 6'd2;
    #1;
    chk("resweep_done", 32'(init_busy), 32'd0);
    chk("p2_v", rd_ps1_v[0], 32'd0);
    chk("p2_rdy", 32'(rd_ps1_rdy[0]), 32'd1);
    step();
    repeat (20) begin
      rand_reads();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
